// File: rtl/shift_pkg.sv
// Shared definitions for the multicycle shifter: op encodings, FSM states and default sizes.
package shift_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_RSV = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational one-bit shift of a WIDTH-bit value; the reserved op passes the value through.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = shift_pkg::WIDTH
) (
  input  shift_op_e        op,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] stepped
);

  always_comb begin
    stepped = value;
    case (op)
      SHIFT_SLL: stepped = {value[WIDTH-2:0], 1'b0};
      SHIFT_SRL: stepped = {1'b0, value[WIDTH-1:1]};
      SHIFT_SRA: stepped = {value[WIDTH-1], value[WIDTH-1:1]};
      default:   stepped = value;
    endcase
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Multicycle SLL/SRL/SRA unit: shifts one bit per clock after an accepted start, pulses done once.
module shift_seq_unit
  import shift_pkg::*;
#(
  parameter int WIDTH   = shift_pkg::WIDTH,
  parameter int SHAMT_W = shift_pkg::SHAMT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  state_e             state_q, state_d;
  shift_op_e          op_q, op_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   step_res;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_q),
    .value   (result_q),
    .stepped (step_res)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_q     <= SHIFT_SLL;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  // Inputs are only looked at in IDLE, so a start while busy is simply dropped.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    count_d  = count_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          result_d = operand;
          op_d     = shift_op_e'(op);
          count_d  = shamt;
          if ((shamt == '0) || (shift_op_e'(op) == SHIFT_RSV)) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        result_d = step_res;
        count_d  = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule
